// File: rtl/pe_pkg.sv
// Shared definitions for the 3x3 MAC processing-element sequencer:
// FSM states, default widths/kernel size and the pe mode encoding.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    localparam int PE_DW   = 8;
    localparam int PE_K    = 3;
    localparam int PE_TAPS = PE_K * PE_K;

    // pe mode_i: 0 = idle/clear, 1 = accumulate the tap presented this cycle
    localparam logic PE_MODE_IDLE = 1'b0;
    localparam logic PE_MODE_ACC  = 1'b1;

endpackage

// File: rtl/pe_win_addr.sv
// Window/tap counters for the KxK raster and the pixel/weight address generation.
// Addresses read 0 outside FEED so the RAM ports stay quiet between windows.
module pe_win_addr
    import pe_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = PE_K,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          feed_i,
    input  logic          tap_adv_i,
    input  logic          win_adv_i,
    output logic [AW-1:0] img_addr_o,
    output logic [3:0]    fil_addr_o,
    output logic [7:0]    row_o,
    output logic [7:0]    col_o,
    output logic          last_tap_o,
    output logic          last_win_o
);

    localparam logic [3:0] K_M1  = 4'(K - 1);
    localparam logic [7:0] OW_M1 = 8'(IMG_W - K);
    localparam logic [7:0] OH_M1 = 8'(IMG_H - K);

    logic [3:0] kx_q, kx_d;
    logic [3:0] ky_q, ky_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;

    always_comb begin
        kx_d  = kx_q;
        ky_d  = ky_q;
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            kx_d  = '0;
            ky_d  = '0;
            row_d = '0;
            col_d = '0;
        end else begin
            // kx is the fast index so taps go ky-major
            if (tap_adv_i) begin
                if (kx_q == K_M1) begin
                    kx_d = '0;
                    ky_d = (ky_q == K_M1) ? 4'd0 : ky_q + 4'd1;
                end else begin
                    kx_d = kx_q + 4'd1;
                end
            end
            if (win_adv_i) begin
                if (col_q == OW_M1) begin
                    col_d = '0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_q  <= '0;
            ky_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            kx_q  <= kx_d;
            ky_q  <= ky_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign img_addr_o = feed_i ? ((AW'(row_q) + AW'(ky_q)) * AW'(IMG_W) + AW'(col_q) + AW'(kx_q))
                               : '0;
    assign fil_addr_o = feed_i ? (ky_q * 4'(K) + kx_q) : 4'd0;
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign last_tap_o = (kx_q == K_M1) && (ky_q == K_M1);
    assign last_win_o = (col_q == OW_M1) && (row_q == OH_M1);

endmodule

// File: rtl/pe_conv_ctrl.sv
// Sequencer for one 3x3 MAC pe: feeds each window's taps from the pixel and
// weight RAMs, waits for the pe result and hands it downstream on valid/ready.
module pe_conv_ctrl
    import pe_pkg::*;
#(
    parameter int DW    = PE_DW,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = PE_K,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] img_addr_o,
    input  logic [DW-1:0] img_data_i,
    output logic [3:0]    fil_addr_o,
    input  logic [DW-1:0] fil_data_i,
    output logic          pe_mode_o,
    output logic [DW-1:0] pe_in_o,
    output logic [DW-1:0] pe_filter_o,
    input  logic [DW-1:0] pe_out_i,
    input  logic          pe_done_i,
    output logic [DW-1:0] res_data_o,
    output logic [7:0]    res_row_o,
    output logic [7:0]    res_col_o,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic          err_o
);

    state_e        state_q, state_d;
    logic          pe_mode_q, pe_mode_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          err_q, err_d;

    logic go, accept, capture, last_tap, last_win;

    assign go      = (state_q == ST_IDLE) && start_i && !abort_i;
    assign accept  = (state_q == ST_OUT) && res_ready_i && !abort_i;
    assign capture = (state_q == ST_WAIT) && pe_done_i && !abort_i;

    pe_win_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .AW    (AW)
    ) u_win_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (go),
        .feed_i     (state_q == ST_FEED),
        .tap_adv_i  ((state_q == ST_FEED) && !abort_i),
        .win_adv_i  (accept && !last_win),
        .img_addr_o (img_addr_o),
        .fil_addr_o (fil_addr_o),
        .row_o      (res_row_o),
        .col_o      (res_col_o),
        .last_tap_o (last_tap),
        .last_win_o (last_win)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_FEED;
            ST_FEED:  if (last_tap) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_WAIT;
            ST_WAIT:  if (pe_done_i) state_d = ST_OUT;
            ST_OUT:   if (res_ready_i) state_d = last_win ? ST_FIN : ST_FEED;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;

        // RAM read latency is one cycle, so the pe sees data one cycle after FEED
        pe_mode_d   = ((state_q == ST_FEED) && !abort_i) ? PE_MODE_ACC : PE_MODE_IDLE;
        res_valid_d = (state_d == ST_OUT);
        res_data_d  = capture ? pe_out_i : res_data_q;

        err_d = err_q;
        if (go) err_d = 1'b0;
        if (pe_done_i && (state_q != ST_WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pe_mode_q   <= PE_MODE_IDLE;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pe_mode_q   <= pe_mode_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN) && !abort_i;
    assign pe_mode_o   = pe_mode_q;
    assign pe_in_o     = img_data_i;
    assign pe_filter_o = fil_data_i;
    assign res_data_o  = res_data_q;
    assign res_valid_o = res_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Directed bench for pe_conv_ctrl on a 4x4 map with a 3x3 kernel (2x2 windows),
// with RAM models and a behavioural 9-tap accumulate pe.
module tb_pe_conv_ctrl;
    import pe_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          start_i, abort_i, res_ready_i;
    logic          busy_o, done_o, pe_mode_o, res_valid_o, err_o;
    logic [AW-1:0] img_addr_o;
    logic [3:0]    fil_addr_o;
    logic [DW-1:0] img_data_i, fil_data_i, pe_in_o, pe_filter_o, pe_out_i, res_data_o;
    logic [7:0]    res_row_o, res_col_o;
    logic          pe_done_i;

    logic [DW-1:0] img_mem [16];
    logic [DW-1:0] fil_mem [9];

    logic [DW-1:0] acc;
    int            cnt;
    logic          pe_done_m;
    logic          force_done;
    logic          pe_clr;
    logic          mon_en;

    int total = 0;
    int bad   = 0;

    pe_conv_ctrl #(.DW(DW), .IMG_W(4), .IMG_H(4), .K(3), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .img_addr_o  (img_addr_o),
        .img_data_i  (img_data_i),
        .fil_addr_o  (fil_addr_o),
        .fil_data_i  (fil_data_i),
        .pe_mode_o   (pe_mode_o),
        .pe_in_o     (pe_in_o),
        .pe_filter_o (pe_filter_o),
        .pe_out_i    (pe_out_i),
        .pe_done_i   (pe_done_i),
        .res_data_o  (res_data_o),
        .res_row_o   (res_row_o),
        .res_col_o   (res_col_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        img_data_i <= img_mem[img_addr_o];
        fil_data_i <= (fil_addr_o < 4'd9) ? fil_mem[fil_addr_o] : '0;
    end

    // Behavioural pe: accumulates while mode is high, pulses done one cycle after tap 9
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; cnt <= 0; pe_done_m <= 1'b0; pe_out_i <= '0;
        end else if (pe_clr) begin
            acc <= '0; cnt <= 0; pe_done_m <= 1'b0;
        end else begin
            pe_done_m <= 1'b0;
            if (pe_mode_o) begin
                if (cnt == PE_TAPS - 1) begin
                    pe_out_i  <= acc + pe_in_o * pe_filter_o;
                    pe_done_m <= 1'b1;
                    acc <= '0;
                    cnt <= 0;
                end else begin
                    acc <= acc + pe_in_o * pe_filter_o;
                    cnt <= cnt + 1;
                end
            end
        end
    end

    assign pe_done_i = pe_done_m | force_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode-run length, pe data alignment and no mode during a held result
    int          run_len = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [3:0]  prev_fil = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_mode_o) begin
                run_len++;
                check("pe_in_align", 32'(pe_in_o), 32'(img_mem[prev_addr]));
                check("pe_filter_align", 32'(pe_filter_o), 32'(fil_mem[prev_fil]));
                check("mode_vs_valid", 32'(res_valid_o), 0);
            end else if (run_len != 0) begin
                if (mon_en) check("mode_run_len", run_len, PE_TAPS);
                run_len = 0;
            end
            prev_addr = img_addr_o;
            prev_fil  = (fil_addr_o < 4'd9) ? fil_addr_o : 4'd0;
        end else begin
            run_len = 0;
        end
    end

    task automatic expect_result(input int ed, input int er, input int ec);
        int n;
        n = 0;
        tick();
        while (!res_valid_o && n < 100) begin
            tick();
            n++;
        end
        check("res_wait", 32'(n < 100), 1);
        check("res_data", 32'(res_data_o), ed);
        check("res_row", 32'(res_row_o), er);
        check("res_col", 32'(res_col_o), ec);
        $display("result row=%0d col=%0d data=%0d", res_row_o, res_col_o, res_data_o);
    endtask

    task automatic finish_pass();
        tick();
        check("done_pulse", 32'(done_o), 1);
        tick();
        check("done_once", 32'(done_o), 0);
        check("busy_after", 32'(busy_o), 0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int exp_addr [9];
        int dcount;
        exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; res_ready_i = 1'b1;
        force_done = 1'b0; pe_clr = 1'b0; mon_en = 1'b1;
        for (int i = 0; i < 16; i++) img_mem[i] = 8'd1;
        for (int i = 0; i < 9; i++) fil_mem[i] = 8'd1;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_addr", 32'(img_addr_o), 0);
        check("rst_mode", 32'(pe_mode_o), 0);
        check("rst_valid", 32'(res_valid_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_n = 1'b1;
        tick();

        // 1: all ones
        pulse_start();
        check("t1_busy", 32'(busy_o), 1);
        expect_result(9, 0, 0);
        expect_result(9, 0, 1);
        expect_result(9, 1, 0);
        expect_result(9, 1, 1);
        finish_pass();
        check("t1_err", 32'(err_o), 0);

        // 2: pixel[a] = a, window-0 address sequence
        for (int i = 0; i < 16; i++) img_mem[i] = 8'(i);
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            check("t2_img_addr", 32'(img_addr_o), exp_addr[i]);
            check("t2_fil_addr", 32'(fil_addr_o), i);
            if (i < 8) tick();
        end
        expect_result(45, 0, 0);
        expect_result(54, 0, 1);
        expect_result(81, 1, 0);
        expect_result(90, 1, 1);
        finish_pass();

        // 4: backpressure in OUT
        res_ready_i = 1'b0;
        pulse_start();
        expect_result(45, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 32'(res_valid_o), 1);
            check("t4_hold_data", 32'(res_data_o), 45);
            check("t4_hold_row", 32'(res_row_o), 0);
            check("t4_hold_col", 32'(res_col_o), 0);
        end
        res_ready_i = 1'b1;
        tick();
        check("t4_valid_drop", 32'(res_valid_o), 0);
        check("t4_feed_tap0", 32'(img_addr_o), 1);
        tick();
        check("t4_feed_tap1", 32'(img_addr_o), 2);
        expect_result(54, 0, 1);
        expect_result(81, 1, 0);
        expect_result(90, 1, 1);
        finish_pass();

        // 5: abort during FEED of window 2
        pulse_start();
        expect_result(45, 0, 0);
        expect_result(54, 0, 1);
        tick();
        check("t5_win2_tap0", 32'(img_addr_o), 4);
        tick();
        check("t5_win2_tap1", 32'(img_addr_o), 5);
        mon_en = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t5_abort_busy", 32'(busy_o), 0);
        check("t5_abort_mode", 32'(pe_mode_o), 0);
        check("t5_abort_valid", 32'(res_valid_o), 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_o) dcount++;
        end
        check("t5_no_done", dcount, 0);
        pe_clr = 1'b1;
        tick();
        pe_clr = 1'b0;
        mon_en = 1'b1;
        pulse_start();
        expect_result(45, 0, 0);
        expect_result(54, 0, 1);
        expect_result(81, 1, 0);
        expect_result(90, 1, 1);
        finish_pass();

        // 6: stray pe_done in FEED sets sticky err, next start clears it
        pulse_start();
        tick();
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("t6_err_set", 32'(err_o), 1);
        expect_result(45, 0, 0);
        expect_result(54, 0, 1);
        expect_result(81, 1, 0);
        expect_result(90, 1, 1);
        finish_pass();
        check("t6_err_sticky", 32'(err_o), 1);
        pulse_start();
        check("t6_err_clear", 32'(err_o), 0);

        // reset while in WAIT
        repeat (10) tick();
        check("t6_wait_busy", 32'(busy_o), 1);
        check("t6_wait_valid", 32'(res_valid_o), 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy_o), 0);
        check("t6_rst_done", 32'(done_o), 0);
        check("t6_rst_addr", 32'(img_addr_o), 0);
        check("t6_rst_fil", 32'(fil_addr_o), 0);
        check("t6_rst_mode", 32'(pe_mode_o), 0);
        check("t6_rst_valid", 32'(res_valid_o), 0);
        check("t6_rst_data", 32'(res_data_o), 0);
        check("t6_rst_row", 32'(res_row_o), 0);
        check("t6_rst_col", 32'(res_col_o), 0);
        check("t6_rst_err", 32'(err_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
